// File: rtl/sseg_mux_scanner.sv
// Multiplexed seven-segment scanner: one shared active-low segment bus, per-slot
// anode dead-time, frame PWM brightness, per-digit blink and leading-zero blanking.
module sseg_mux_scanner #(
  parameter int N_DIGITS     = 8,
  parameter int DIV_WIDTH    = 16,
  parameter int BLANK_CYCLES = 4,
  parameter int BRIGHT_WIDTH = 3,
  parameter int BLINK_WIDTH  = 24
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          en,
  input  logic [DIV_WIDTH-1:0]          refresh_div,
  input  logic [BRIGHT_WIDTH-1:0]       brightness,
  input  logic [6*N_DIGITS-1:0]         digits,
  input  logic [N_DIGITS-1:0]           blink_mask,
  input  logic                          lz_blank,
  output logic [N_DIGITS-1:0]           AN,
  output logic [6:0]                    sseg,
  output logic                          DP,
  output logic [$clog2(N_DIGITS)-1:0]   digit_sel,
  output logic                          frame_tick
);

  localparam int SEL_W = $clog2(N_DIGITS);
  localparam logic [SEL_W-1:0]    LAST_SEL = SEL_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] ONE_HOT0 = N_DIGITS'(1);

  logic [DIV_WIDTH-1:0]    div;
  logic [DIV_WIDTH-1:0]    len;
  logic [BRIGHT_WIDTH-1:0] pwm;
  logic [BLINK_WIDTH-1:0]  blink_cnt;
  logic [N_DIGITS-1:0]     lz_supp;
  logic                    higher_dark;
  logic                    supp_i;
  logic [5:0]              cur;
  logic                    lit;

  function automatic logic [6:0] hex_glyph(input logic [3:0] h);
    case (h)
      4'h0: hex_glyph = 7'h40;
      4'h1: hex_glyph = 7'h79;
      4'h2: hex_glyph = 7'h24;
      4'h3: hex_glyph = 7'h30;
      4'h4: hex_glyph = 7'h19;
      4'h5: hex_glyph = 7'h12;
      4'h6: hex_glyph = 7'h02;
      4'h7: hex_glyph = 7'h78;
      4'h8: hex_glyph = 7'h00;
      4'h9: hex_glyph = 7'h10;
      4'hA: hex_glyph = 7'h08;
      4'hB: hex_glyph = 7'h03;
      4'hC: hex_glyph = 7'h46;
      4'hD: hex_glyph = 7'h21;
      4'hE: hex_glyph = 7'h06;
      default: hex_glyph = 7'h0E;
    endcase
  endfunction

  // Walk from the most significant digit down; a zero digit is blanked only while
  // everything above it is already dark (disabled or itself blanked).
  always_comb begin
    lz_supp     = '0;
    higher_dark = 1'b1;
    supp_i      = 1'b0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      supp_i      = lz_blank && (digits[6*i+1 +: 4] == 4'h0) && higher_dark;
      lz_supp[i]  = supp_i;
      higher_dark = higher_dark && (!digits[6*i+5] || supp_i);
    end
  end

  always_comb begin
    cur = digits[6*digit_sel +: 6];
    lit = en
       && (32'(div) >= BLANK_CYCLES)
       && cur[5]
       && (pwm <= brightness)
       && !(blink_mask[digit_sel] && blink_cnt[BLINK_WIDTH-1])
       && !lz_supp[digit_sel];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div        <= '0;
      len        <= refresh_div;
      digit_sel  <= '0;
      pwm        <= '0;
      blink_cnt  <= '0;
      AN         <= '1;
      sseg       <= 7'h7F;
      DP         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (lit) begin
        AN   <= ~(ONE_HOT0 << digit_sel);
        sseg <= hex_glyph(cur[4:1]);
        DP   <= ~cur[0];
      end else begin
        AN   <= '1;
        sseg <= 7'h7F;
        DP   <= 1'b1;
      end
      if (en) begin
        blink_cnt <= blink_cnt + 1'b1;
        // Slot length is only re-sampled here, so mid-slot changes wait for the boundary.
        if (div == len) begin
          div <= '0;
          len <= refresh_div;
          if (digit_sel == LAST_SEL) begin
            digit_sel  <= '0;
            pwm        <= pwm + 1'b1;
            frame_tick <= 1'b1;
          end else begin
            digit_sel <= digit_sel + 1'b1;
          end
        end else begin
          div <= div + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sseg_mux_scanner.sv
// Bench for sseg_mux_scanner (4 digits, 2 dead cycles, 4-bit blink counter):
// glyph/blanking vector table, hand-written timing sequences and a random run.
module tb_sseg_mux_scanner;

  localparam int ND = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic [15:0] refresh_div;
  logic [2:0]  brightness;
  logic [23:0] digits;
  logic [3:0]  blink_mask;
  logic        lz_blank;
  logic [3:0]  AN;
  logic [6:0]  sseg;
  logic        DP;
  logic [1:0]  digit_sel;
  logic        frame_tick;

  int tests = 0;
  int fails = 0;

  // reference model state, kept as plain integers
  int m_slot, m_pos, m_len, m_frames, m_en_cycles;
  logic [14:0] exp_q[$];

  sseg_mux_scanner #(
    .N_DIGITS(ND), .DIV_WIDTH(16), .BLANK_CYCLES(2), .BRIGHT_WIDTH(3), .BLINK_WIDTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .refresh_div(refresh_div),
    .brightness(brightness), .digits(digits), .blink_mask(blink_mask),
    .lz_blank(lz_blank), .AN(AN), .sseg(sseg), .DP(DP),
    .digit_sel(digit_sel), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [6:0] ref_glyph(input int h);
    logic [6:0] on;
    case (h)
      0: on = 7'h3F;  1: on = 7'h06;  2: on = 7'h5B;  3: on = 7'h4F;
      4: on = 7'h66;  5: on = 7'h6D;  6: on = 7'h7D;  7: on = 7'h07;
      8: on = 7'h7F;  9: on = 7'h6F;  10: on = 7'h77; 11: on = 7'h7C;
      12: on = 7'h39; 13: on = 7'h5E; 14: on = 7'h79; default: on = 7'h71;
    endcase
    return ~on;
  endfunction

  function automatic int hex_of(input int i);
    return int'(digits[6*i+1 +: 4]);
  endfunction

  function automatic bit ref_lz(input int i);
    if (!lz_blank || i == 0 || hex_of(i) != 0) return 1'b0;
    for (int j = i + 1; j < ND; j++)
      if (digits[6*j+5] && hex_of(j) != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [5:0] mk(input bit e, input int h, input bit d);
    return {e, 4'(h), d};
  endfunction

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // One clock: predict from the model, advance it, then compare after the edge.
  task automatic step();
    logic       lit;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_ft;
    logic [14:0] got, e;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_ft = 1'b0;
    if (!reset_n) begin
      m_slot = 0; m_pos = 0; m_len = int'(refresh_div); m_frames = 0; m_en_cycles = 0;
    end else begin
      lit = en && (m_pos >= 2) && digits[6*m_slot+5]
         && ((m_frames % 8) <= int'(brightness))
         && !(blink_mask[m_slot] && ((m_en_cycles / 8) % 2 == 1))
         && !ref_lz(m_slot);
      if (lit) begin
        e_an  = 4'hF ^ (4'h1 << m_slot);
        e_seg = ref_glyph(hex_of(m_slot));
        e_dp  = ~digits[6*m_slot];
      end
      if (en) begin
        m_en_cycles++;
        if (m_pos == m_len) begin
          m_pos  = 0;
          m_len  = int'(refresh_div);
          m_slot = (m_slot + 1) % ND;
          if (m_slot == 0) begin
            m_frames++;
            e_ft = 1'b1;
          end
        end else begin
          m_pos++;
        end
      end
    end
    exp_q.push_back({e_an, e_seg, e_dp, 2'(m_slot), e_ft});
    @(posedge clk);
    #1;
    got = {AN, sseg, DP, digit_sel, frame_tick};
    e = exp_q.pop_front();
    tests++;
    if (got !== e) begin
      fails++;
      $display("FAIL model t=%0t: got AN=%b sseg=%h DP=%b sel=%0d ft=%b, expected AN=%b sseg=%h DP=%b sel=%0d ft=%b",
               $time, AN, sseg, DP, digit_sel, frame_tick,
               e[14:11], e[10:4], e[3], e[2:1], e[0]);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [23:0] digits;
    logic        lz;
    int          slot;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [23:0] d_a, d_b, d_d, d_e;
    int cnt0, cnt1, lit_cnt, tick_cnt, first_tick, c1, c2, prev_sel;
    logic [7:0] lit_frames;

    reset_n = 1'b0; en = 1'b1; refresh_div = 16'd9; brightness = 3'd7;
    digits = '0; blink_mask = '0; lz_blank = 1'b0;

    d_a = {mk(1, 4, 0), mk(1, 3, 0), mk(1, 2, 0), mk(1, 1, 0)};
    d_b = {mk(1, 0, 0), mk(1, 0, 0), mk(1, 5, 1), mk(1, 0, 0)};
    d_d = {mk(1, 0, 1), mk(0, 10, 0), mk(1, 0, 1), mk(1, 7, 0)};
    d_e = {mk(1, 15, 0), mk(1, 0, 0), mk(1, 0, 1), mk(1, 0, 0)};
    vecs[0]  = '{d_a, 1'b0, 0, 4'b1110, 7'h79, 1'b1};
    vecs[1]  = '{d_a, 1'b0, 2, 4'b1011, 7'h30, 1'b1};
    vecs[2]  = '{d_a, 1'b0, 3, 4'b0111, 7'h19, 1'b1};
    vecs[3]  = '{d_b, 1'b1, 3, 4'b1111, 7'h7F, 1'b1};
    vecs[4]  = '{d_b, 1'b1, 2, 4'b1111, 7'h7F, 1'b1};
    vecs[5]  = '{d_b, 1'b1, 1, 4'b1101, 7'h12, 1'b0};
    vecs[6]  = '{d_b, 1'b1, 0, 4'b1110, 7'h40, 1'b1};
    vecs[7]  = '{d_b, 1'b0, 3, 4'b0111, 7'h40, 1'b1};
    vecs[8]  = '{d_d, 1'b1, 1, 4'b1111, 7'h7F, 1'b1};
    vecs[9]  = '{d_d, 1'b1, 3, 4'b1111, 7'h7F, 1'b1};
    vecs[10] = '{d_d, 1'b1, 0, 4'b1110, 7'h78, 1'b1};
    vecs[11] = '{d_e, 1'b1, 3, 4'b0111, 7'h0E, 1'b1};
    vecs[12] = '{d_e, 1'b1, 2, 4'b1011, 7'h40, 1'b1};
    vecs[13] = '{d_e, 1'b1, 1, 4'b1101, 7'h40, 1'b0};

    // reset state
    do_reset();
    check("reset_an", int'(AN), 4'hF);
    check("reset_sseg", int'(sseg), 7'h7F);
    check("reset_dp", int'(DP), 1);
    check("reset_sel", int'(digit_sel), 0);
    check("reset_ft", int'(frame_tick), 0);

    // vector table: sample the middle of the chosen slot
    for (int v = 0; v < 14; v++) begin
      digits = vecs[v].digits; lz_blank = vecs[v].lz;
      refresh_div = 16'd9; brightness = 3'd7; blink_mask = '0; en = 1'b1;
      do_reset();
      repeat (10 * vecs[v].slot + 6) step();
      check($sformatf("vec%0d_an", v), int'(AN), int'(vecs[v].an));
      check($sformatf("vec%0d_sseg", v), int'(sseg), int'(vecs[v].seg));
      check($sformatf("vec%0d_dp", v), int'(DP), int'(vecs[v].dp));
    end

    // frame_tick period with 10-cycle slots
    digits = d_a; lz_blank = 1'b0;
    do_reset();
    tick_cnt = 0; first_tick = -1;
    for (int n = 1; n <= 81; n++) begin
      step();
      if (frame_tick) begin
        tick_cnt++;
        if (first_tick < 0) first_tick = n;
      end
    end
    check("tick_first", first_tick, 40);
    check("tick_count", tick_cnt, 2);

    // brightness 1: only frames with pwm 0 and 1 light up
    brightness = 3'd1;
    do_reset();
    lit_frames = '0;
    for (int n = 1; n <= 320; n++) begin
      step();
      if (AN != 4'hF) lit_frames[(n - 1) / 40] = 1'b1;
    end
    check("pwm_frames", int'(lit_frames), 8'b0000_0011);
    brightness = 3'd7;

    // blink on digit 1 only
    blink_mask = 4'b0010;
    do_reset();
    cnt0 = 0; cnt1 = 0;
    for (int n = 1; n <= 161; n++) begin
      step();
      if (AN == 4'b1110) cnt0++;
      if (AN == 4'b1101) cnt1++;
    end
    check("blink_d1_lit", cnt1, 16);
    check("blink_d0_lit", cnt0, 32);
    blink_mask = '0;

    // reset at div 5 of slot 2
    do_reset();
    repeat (25) step();
    check("pre_reset_sel", int'(digit_sel), 2);
    reset_n = 1'b0;
    step();
    check("midreset_an", int'(AN), 4'hF);
    check("midreset_sel", int'(digit_sel), 0);
    reset_n = 1'b1;
    repeat (2) step();
    check("post_reset_dark", int'(AN), 4'hF);
    step();
    check("post_reset_first_lit", int'(AN), 4'b1110);

    // en low holds the scan and darkens the display
    do_reset();
    repeat (15) step();
    en = 1'b0;
    step();
    check("en0_dark", int'(AN), 4'hF);
    repeat (5) step();
    check("en0_hold_sel", int'(digit_sel), 1);
    en = 1'b1;
    step();
    check("en1_resume", int'(AN), 4'b1101);

    // refresh_div change mid-slot takes effect at the boundary
    refresh_div = 16'd9;
    do_reset();
    repeat (4) step();
    refresh_div = 16'd3;
    c1 = -1; c2 = -1; prev_sel = 0;
    for (int n = 5; n <= 20; n++) begin
      step();
      if (int'(digit_sel) != prev_sel) begin
        if (c1 < 0) c1 = n;
        else if (c2 < 0) c2 = n;
      end
      prev_sel = int'(digit_sel);
    end
    check("div_change_slot0_end", c1, 10);
    check("div_change_slot1_end", c2, 14);

    // slot shorter than dead time: dark but still scanning
    refresh_div = 16'd1;
    do_reset();
    lit_cnt = 0; tick_cnt = 0;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (AN != 4'hF) lit_cnt++;
      if (frame_tick) tick_cnt++;
    end
    check("short_slot_dark", lit_cnt, 0);
    check("short_slot_ticks", tick_cnt, 5);

    // random run against the model
    refresh_div = 16'd5;
    do_reset();
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 299) == 0) reset_n = 1'b0;
      else reset_n = 1'b1;
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) refresh_div = 16'($urandom_range(0, 12));
      if ($urandom_range(0, 19) == 0) brightness = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) blink_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) lz_blank = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0)
        for (int i = 0; i < ND; i++)
          digits[6*i +: 6] = {1'($urandom_range(0, 3) != 0),
                              ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
                              1'($urandom_range(0, 1))};
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
